// File: rtl/morse_pkg.sv
// morse_pkg: Morse code tables, transmitter state type and ASCII lookup.
// value[0] is the first symbol sent; a 1 bit is a dash.
package morse_pkg;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] value;
    } morse_char_t;

    typedef struct packed {
        logic        unknown;
        logic        space;
        morse_char_t code;
    } morse_char_or_unknown_t;

    localparam int DASH_UNITS     = 3;
    localparam int SYM_GAP_UNITS  = 1;
    localparam int CHAR_GAP_UNITS = 3;

    localparam morse_char_t letter_conversion_c [26] = '{
        8'b010_00010, 8'b100_00001, 8'b100_00101, 8'b011_00001, 8'b001_00000,
        8'b100_00100, 8'b011_00011, 8'b100_00000, 8'b010_00000, 8'b100_01110,
        8'b011_00101, 8'b100_00010, 8'b010_00011, 8'b010_00001, 8'b011_00111,
        8'b100_00110, 8'b100_01011, 8'b011_00010, 8'b011_00000, 8'b001_00001,
        8'b011_00100, 8'b100_01000, 8'b011_00110, 8'b100_01001, 8'b100_01101,
        8'b100_00011
    };

    localparam morse_char_t number_conversion_c [10] = '{
        8'b101_11111, 8'b101_11110, 8'b101_11100, 8'b101_11000, 8'b101_10000,
        8'b101_00000, 8'b101_00001, 8'b101_00011, 8'b101_00111, 8'b101_01111
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SYM_GAP,
        CHAR_GAP,
        WORD_GAP
    } morse_tx_state_t;

    // Offsets wrap below zero, so one unsigned compare checks each range.
    function automatic morse_char_or_unknown_t ascii_to_morse(input logic [7:0] c);
        morse_char_or_unknown_t r;
        logic [7:0] u, l, d;
        u = c - 8'd65;
        l = c - 8'd97;
        d = c - 8'd48;
        r = '0;
        if (u < 8'd26) r.code = letter_conversion_c[u[4:0]];
        else if (l < 8'd26) r.code = letter_conversion_c[l[4:0]];
        else if (d < 8'd10) r.code = number_conversion_c[d[3:0]];
        else if (c == 8'd32 || c == 8'd13) r.space = 1'b1;
        else r.unknown = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/morse_tx_fifo.sv
// morse_tx_fifo: character FIFO with registered full/empty flags and clear.
module morse_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          wr, rd;

    assign rd        = rd_en_i && !empty_o;
    assign wr        = wr_en_i && (!full_o || rd);
    assign count_d   = clear_i ? '0 : count_q + (AW+1)'(wr) - (AW+1)'(rd);
    assign rd_data_o = mem[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
        end else begin
            wr_ptr_q <= clear_i ? '0 : wr_ptr_q + AW'(wr);
            rd_ptr_q <= clear_i ? '0 : rd_ptr_q + AW'(rd);
            count_q  <= count_d;
            full_o   <= count_d == (AW+1)'(DEPTH);
            empty_o  <= count_d == '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/morse_tx_serializer.sv
// morse_tx_serializer: buffered ASCII to on/off keyed Morse transmitter.
// Define MORSE_TX_STATUS_EN to add the chars_sent_o / chars_dropped_o counters.
module morse_tx_serializer
    import morse_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int DOT_PERIOD_W   = 28,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [7:0]              char_i,
    input  logic                    char_valid_i,
    output logic                    char_ready_o,
    input  logic [DOT_PERIOD_W-1:0] dot_period_i,
    input  logic                    abort_i,
    output logic                    morse_o,
    output logic                    busy_o,
    output logic                    error_o
`ifdef MORSE_TX_STATUS_EN
    ,
    output logic [15:0]             chars_sent_o,
    output logic [15:0]             chars_dropped_o
`endif
);
    localparam int CW = DOT_PERIOD_W + 2;

    morse_tx_state_t           state_q, state_d;
    morse_char_or_unknown_t    conv_q;
    logic [DOT_PERIOD_W-1:0]   unit_q;
    logic [CW-1:0]             cnt_q, units, target, limit;
    logic [2:0]                sym_q;
    logic [7:0]                fifo_data;
    logic                      fifo_full, fifo_empty, wr, pop, expire, more, dash;
    logic                      morse_d, busy_d, error_d;

    assign char_ready_o = !fifo_full;
    assign wr           = char_valid_i && char_ready_o && !abort_i;
    assign pop          = state_q == IDLE && !fifo_empty && !abort_i;

    morse_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (abort_i),
        .wr_en_i   (wr),
        .wr_data_i (char_i),
        .rd_en_i   (pop),
        .rd_data_o (fifo_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign dash   = conv_q.code.value[sym_q];
    assign more   = sym_q + 3'd1 < conv_q.code.len;
    assign units  = state_q == MARK     ? CW'(dash ? DASH_UNITS : 1) :
                    state_q == SYM_GAP  ? CW'(SYM_GAP_UNITS) :
                    state_q == CHAR_GAP ? CW'(CHAR_GAP_UNITS) : CW'(WORD_GAP_UNITS - 3);
    assign target = units * CW'(unit_q) - CW'(1);
    // The IDLE and LOAD cycles before the next mark are part of the gap, so trim them when a character waits.
    assign limit  = (state_q inside {CHAR_GAP, WORD_GAP}) && !fifo_empty && target >= CW'(2) ?
                    target - CW'(2) : target;
    assign expire = cnt_q >= limit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            morse_o <= 1'b0;
            busy_o  <= 1'b0;
            error_o <= 1'b0;
        end else begin
            state_q <= state_d;
            morse_o <= morse_d;
            busy_o  <= busy_d;
            error_o <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) state_d = IDLE;
        else
            case (state_q)
                IDLE:    state_d = fifo_empty ? IDLE : LOAD;
                LOAD:    state_d = conv_q.unknown ? IDLE : conv_q.space ? WORD_GAP : MARK;
                MARK:    state_d = !expire ? MARK : more ? SYM_GAP : CHAR_GAP;
                SYM_GAP: state_d = expire ? MARK : SYM_GAP;
                default: state_d = expire ? IDLE : state_q;
            endcase
    end

    always_comb begin
        morse_d = !abort_i && state_q == MARK;
        busy_d  = !abort_i && (state_q != IDLE || !fifo_empty);
        error_d = !abort_i && state_q == LOAD && conv_q.unknown;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            sym_q  <= '0;
            unit_q <= '0;
            conv_q <= '0;
        end else begin
            cnt_q <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
            if (pop) begin
                conv_q <= ascii_to_morse(fifo_data);
                unit_q <= dot_period_i == '0 ? DOT_PERIOD_W'(1) : dot_period_i;
            end
            if (state_q == LOAD) sym_q <= '0;
            else if (state_q == MARK && state_d == SYM_GAP) sym_q <= sym_q + 3'd1;
        end
    end

`ifdef MORSE_TX_STATUS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chars_sent_o    <= '0;
            chars_dropped_o <= '0;
        end else begin
            if (state_d != state_q && (state_d inside {CHAR_GAP, WORD_GAP}))
                chars_sent_o <= chars_sent_o + 16'd1;
            if (error_d) chars_dropped_o <= chars_dropped_o + 16'd1;
        end
    end
`endif

endmodule
